// File: rtl/mc_pc_ir_unit.sv
// Multicycle MIPS datapath register block: PC, IR, MDR and ALUOut, plus
// conditional PC-write resolution and retired-instruction / cycle counters.
module mc_pc_ir_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             BeQ,
    input  logic             BnE,
    input  logic [1:0]       PCSrc,
    input  logic             IRWrite,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       op,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] alu_out,
    output logic             pc_misalign,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [1:0] SRC_ALU    = 2'b00;
    localparam logic [1:0] SRC_ALUOUT = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_HOLD   = 2'b11;

    logic [WIDTH-1:0] pc_q,      pc_d;
    logic [WIDTH-1:0] instr_q,   instr_d;
    logic [WIDTH-1:0] mdr_q,     mdr_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             mis_q,     mis_d;
    logic [CNT_W-1:0] icnt_q,    icnt_d;
    logic [CNT_W-1:0] ccnt_q,    ccnt_d;

    logic             pc_en_s;
    logic [WIDTH-1:0] pc_sel_s;
    logic [WIDTH-1:0] jump_tgt_s;

    // Branch resolution; BeQ and BnE together always write (illegal, unflagged)
    assign pc_en_s = PCWrite | (BeQ & alu_zero) | (BnE & ~alu_zero);

    // Jump target uses the pre-edge PC (already PC+4) and pre-edge IR
    assign jump_tgt_s = {pc_q[WIDTH-1:28], instr_q[25:0], 2'b00};

    // Next-PC source mux
    always_comb begin
        pc_sel_s = pc_q;
        case (PCSrc)
            SRC_ALU:    pc_sel_s = alu_result;
            SRC_ALUOUT: pc_sel_s = alu_out_q;
            SRC_JUMP:   pc_sel_s = jump_tgt_s;
            SRC_HOLD:   pc_sel_s = pc_q;
            default:    pc_sel_s = pc_q;
        endcase
    end

    // Next-state for PC and the sticky misalignment flag
    always_comb begin
        pc_d  = pc_q;
        mis_d = mis_q;
        if (pc_en_s) begin
            pc_d  = pc_sel_s;
            mis_d = mis_q | (pc_sel_s[1:0] != 2'b00);
        end else begin
            pc_d  = pc_q;
            mis_d = mis_q;
        end
    end

    // Next-state for IR and the IR-load counter
    always_comb begin
        instr_d = instr_q;
        icnt_d  = icnt_q;
        if (IRWrite) begin
            instr_d = mem_rdata;
            icnt_d  = icnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_d = instr_q;
            icnt_d  = icnt_q;
        end
    end

    // Unconditionally loaded registers and the free-running cycle counter
    always_comb begin
        mdr_d     = mem_rdata;
        alu_out_d = alu_result;
        ccnt_d    = ccnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // State registers; reset overrides every strobe on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= {WIDTH{1'b0}};
            mdr_q     <= {WIDTH{1'b0}};
            alu_out_q <= {WIDTH{1'b0}};
            mis_q     <= 1'b0;
            icnt_q    <= {CNT_W{1'b0}};
            ccnt_q    <= {CNT_W{1'b0}};
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            mdr_q     <= mdr_d;
            alu_out_q <= alu_out_d;
            mis_q     <= mis_d;
            icnt_q    <= icnt_d;
            ccnt_q    <= ccnt_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign mdr         = mdr_q;
    assign alu_out     = alu_out_q;
    assign pc_misalign = mis_q;
    assign instr_cnt   = icnt_q;
    assign cycle_cnt   = ccnt_q;

endmodule

// File: tb/tb_mc_pc_ir_unit.sv
// Bench for mc_pc_ir_unit: table of hand-computed vectors plus reset/wrap
// sequences, expectations queued at drive time and compared after the edge.
module tb_mc_pc_ir_unit;

    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst, PCWrite, BeQ, BnE, IRWrite, alu_zero;
    logic [1:0]       PCSrc;
    logic [31:0]      alu_result, mem_rdata;
    logic [31:0]      pc, instr, mdr, alu_out;
    logic [5:0]       op;
    logic             pc_misalign;
    logic [CW-1:0]    instr_cnt, cycle_cnt;

    mc_pc_ir_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .BeQ(BeQ), .BnE(BnE),
        .PCSrc(PCSrc), .IRWrite(IRWrite), .alu_result(alu_result),
        .alu_zero(alu_zero), .mem_rdata(mem_rdata), .pc(pc), .instr(instr),
        .op(op), .mdr(mdr), .alu_out(alu_out), .pc_misalign(pc_misalign),
        .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pcw, beq, bne, irw, z;
        logic [1:0]  src;
        logic [31:0] alu, mem;
        logic [31:0] e_pc, e_instr;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0]   pc, instr, mdr, aluo;
        logic          mis;
        logic [CW-1:0] ic, cyc;
    } exp_t;

    exp_t    sb[$];
    vec_t    tbl[16];
    int      checks = 0;
    int      errors = 0;
    logic [CW-1:0] exp_ic  = '0;
    logic [CW-1:0] exp_cyc = '0;

    function automatic vec_t mk(input logic r, input logic pw, input logic bq,
                                input logic bn, input logic [1:0] s,
                                input logic iw, input logic [31:0] a,
                                input logic zz, input logic [31:0] m,
                                input logic [31:0] epc, input logic [31:0] ein,
                                input logic emis);
        vec_t v;
        v.rst = r; v.pcw = pw; v.beq = bq; v.bne = bn; v.src = s; v.irw = iw;
        v.alu = a; v.z = zz; v.mem = m; v.e_pc = epc; v.e_instr = ein; v.e_mis = emis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = v.rst; PCWrite = v.pcw; BeQ = v.beq; BnE = v.bne; PCSrc = v.src;
        IRWrite = v.irw; alu_result = v.alu; alu_zero = v.z; mem_rdata = v.mem;
        if (v.rst) begin
            exp_cyc = '0;
            exp_ic  = '0;
        end else begin
            exp_cyc = exp_cyc + 1'b1;
            if (v.irw) exp_ic = exp_ic + 1'b1;
        end
        e.pc    = v.e_pc;
        e.instr = v.e_instr;
        e.mis   = v.e_mis;
        e.mdr   = v.rst ? 32'h0 : v.mem;
        e.aluo  = v.rst ? 32'h0 : v.alu;
        e.ic    = exp_ic;
        e.cyc   = exp_cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({tag, ".pc"},      pc,      g.pc);
        chk({tag, ".instr"},   instr,   g.instr);
        chk({tag, ".op"},      {26'h0, op}, {26'h0, g.instr[31:26]});
        chk({tag, ".mdr"},     mdr,     g.mdr);
        chk({tag, ".alu_out"}, alu_out, g.aluo);
        chk({tag, ".misalign"}, {31'h0, pc_misalign}, {31'h0, g.mis});
        chk({tag, ".instr_cnt"}, {28'h0, instr_cnt}, {28'h0, g.ic});
        chk({tag, ".cycle_cnt"}, {28'h0, cycle_cnt}, {28'h0, g.cyc});
    endtask

    initial begin
        vec_t rv;
        vec_t iv;
        // rst pw  bq  bn  src   irw alu            z   mem           e_pc           e_instr        mis
        tbl[0]  = mk(0, 1, 0, 0, 2'b00, 1, 32'h0000_0004, 0, 32'h2008_0005, 32'h0000_0004, 32'h2008_0005, 0);
        tbl[1]  = mk(0, 0, 0, 0, 2'b00, 0, 32'h0000_0100, 0, 32'h0000_1111, 32'h0000_0004, 32'h2008_0005, 0);
        tbl[2]  = mk(0, 0, 1, 0, 2'b01, 0, 32'h0000_0000, 1, 32'h0000_2222, 32'h0000_0100, 32'h2008_0005, 0);
        tbl[3]  = mk(0, 0, 0, 0, 2'b00, 0, 32'h0000_0200, 0, 32'h0000_3333, 32'h0000_0100, 32'h2008_0005, 0);
        tbl[4]  = mk(0, 0, 1, 0, 2'b01, 0, 32'h0000_0020, 0, 32'h0000_4444, 32'h0000_0100, 32'h2008_0005, 0);
        tbl[5]  = mk(0, 0, 0, 1, 2'b01, 0, 32'h0000_0300, 0, 32'h0000_5555, 32'h0000_0020, 32'h2008_0005, 0);
        tbl[6]  = mk(0, 0, 0, 1, 2'b01, 0, 32'h0000_0000, 1, 32'h0000_6666, 32'h0000_0020, 32'h2008_0005, 0);
        tbl[7]  = mk(0, 1, 0, 0, 2'b11, 0, 32'h0000_0050, 0, 32'h0000_7777, 32'h0000_0020, 32'h2008_0005, 0);
        tbl[8]  = mk(0, 0, 0, 0, 2'b00, 0, 32'h0000_0044, 0, 32'h0000_8888, 32'h0000_0020, 32'h2008_0005, 0);
        tbl[9]  = mk(0, 1, 0, 0, 2'b00, 1, 32'h1000_0004, 0, 32'h0800_0010, 32'h1000_0004, 32'h0800_0010, 0);
        tbl[10] = mk(0, 1, 0, 0, 2'b10, 0, 32'h0000_0000, 0, 32'h0000_9999, 32'h1000_0040, 32'h0800_0010, 0);
        tbl[11] = mk(0, 1, 0, 0, 2'b10, 1, 32'h0000_0000, 0, 32'h0BFF_FFFF, 32'h1000_0040, 32'h0BFF_FFFF, 0);
        tbl[12] = mk(0, 0, 1, 1, 2'b00, 0, 32'h0000_0080, 0, 32'h0000_AAAA, 32'h0000_0080, 32'h0BFF_FFFF, 0);
        tbl[13] = mk(0, 0, 1, 1, 2'b00, 0, 32'h0000_0084, 1, 32'h0000_BBBB, 32'h0000_0084, 32'h0BFF_FFFF, 0);
        tbl[14] = mk(0, 1, 0, 0, 2'b00, 0, 32'h0000_0006, 0, 32'h0000_CCCC, 32'h0000_0006, 32'h0BFF_FFFF, 1);
        tbl[15] = mk(0, 1, 0, 0, 2'b00, 0, 32'h0000_0008, 0, 32'h0000_DDDD, 32'h0000_0008, 32'h0BFF_FFFF, 1);

        rst = 1'b1; PCWrite = 1'b0; BeQ = 1'b0; BnE = 1'b0; PCSrc = 2'b00;
        IRWrite = 1'b0; alu_result = 32'h0; alu_zero = 1'b0; mem_rdata = 32'h0;

        // Two reset cycles with active strobes; strobes must be ignored
        rv = mk(1, 1, 0, 0, 2'b00, 1, 32'h0000_0040, 0, 32'h0000_DEAD, 32'h0, 32'h0, 0);
        apply(rv, "reset0");
        apply(rv, "reset1");

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Mid-instruction reset clears the sticky flag and counters
        rv = mk(1, 1, 1, 1, 2'b10, 1, 32'h0000_0003, 1, 32'h1234_5678, 32'h0, 32'h0, 0);
        apply(rv, "midreset");

        // 16 IR loads with CNT_W=4: both counters wrap back to zero
        for (int k = 0; k < 16; k++) begin
            iv = mk(0, 0, 0, 0, 2'b00, 1, 32'h0000_0010 + k, 0, 32'h0000_0100 + k,
                    32'h0, 32'h0000_0100 + k, 0);
            apply(iv, $sformatf("wrap%0d", k));
        end
        checks++;
        if (instr_cnt !== 4'd0 || cycle_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_final: instr_cnt=%0d cycle_cnt=%0d expected 0 and 0",
                     instr_cnt, cycle_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_pc_ir_unit.md
Name: mc_pc_ir_unit

Overview:
Sequential register block of the multicycle MIPS datapath, directly downstream of the multicycle control FSM. Holds the architectural PC, Instruction Register (IR), Memory Data Register (MDR) and ALUOut register. Resolves the conditional PC write from the FSM's PCWrite/BeQ/BnE/PCSrc strobes and the ALU zero flag. Feeds the opcode back to the FSM and exposes instruction and cycle counters for verification.

Parameters:
WIDTH, 32, datapath width in bits (PC, IR, MDR, ALUOut)
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of the retired-instruction and cycle counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
PCWrite  in  1  unconditional PC write strobe from control
BeQ  in  1  branch-if-equal strobe from control
BnE  in  1  branch-if-not-equal strobe from control
PCSrc  in  2  next-PC select from control
IRWrite  in  1  IR load strobe from control
alu_result  in  WIDTH  combinational ALU output
alu_zero  in  1  ALU zero flag (alu_result == 0)
mem_rdata  in  WIDTH  unified memory read data
pc  out  WIDTH  current PC (memory address in fetch)
instr  out  WIDTH  IR contents
op  out  6  instr[31:26], to control
mdr  out  WIDTH  MDR contents
alu_out  out  WIDTH  ALUOut register contents
pc_misalign  out  1  sticky: a PC with [1:0] != 0 was written
instr_cnt  out  CNT_W  number of IR loads since reset
cycle_cnt  out  CNT_W  clock cycles since reset

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, instr=0, mdr=0, alu_out=0, pc_misalign=0, instr_cnt=0, cycle_cnt=0. Reset overrides every strobe in the same cycle.
- pc_en = PCWrite | (BeQ & alu_zero) | (BnE & ~alu_zero). Evaluated combinationally, registered at the next posedge.
- Next PC when pc_en=1:
  - PCSrc=00 -> alu_result (PC+4 in fetch)
  - PCSrc=01 -> alu_out (branch target computed in decode)
  - PCSrc=10 -> {pc[31:28], instr[25:0], 2'b00} (jump; pc is already PC+4)
  - PCSrc=11 -> pc held, no write
- pc_en=0: pc holds regardless of PCSrc.
- BeQ and BnE both high in the same cycle: pc_en=1 unconditionally. This is an illegal control combination and is not flagged.
- IR: IRWrite=1 -> instr <= mem_rdata next edge; otherwise hold.
- op is always instr[31:26], zero latency from the IR.
- MDR: loads mem_rdata every cycle, no enable, so it is 1-cycle delayed memory data.
- ALUOut: loads alu_result every cycle, no enable.
- IRWrite and pc_en in the same cycle (fetch state): both update on the same edge. The jump-target mux uses the pre-edge instr and pc.
- pc_misalign: set when pc_en=1 and the selected next-PC has [1:0] != 0. Write still occurs. Cleared only by rst.
- instr_cnt: +1 on each edge with IRWrite=1. Wraps modulo 2^CNT_W without saturating.
- cycle_cnt: +1 every non-reset edge, wraps modulo 2^CNT_W.
- All arithmetic is unsigned; no sign extension occurs inside this block.
- Reset mid-instruction (any control state): all registers return to reset values on that edge. Strobes in the reset cycle are ignored.

Test Plan:
- Reset: hold rst=1 two cycles with PCWrite=1, alu_result=32'h40 -> pc=0, instr_cnt=0, cycle_cnt=0, pc_misalign=0.
- Fetch: mem_rdata=32'h2008_0005, IRWrite=1, PCWrite=1, PCSrc=00, alu_result=32'h4 -> next edge instr=32'h2008_0005, op=6'b001000, pc=4, instr_cnt=1.
- BEQ: alu_out preloaded with 32'h100; BeQ=1, PCSrc=01. With alu_zero=1 -> pc=32'h100. Repeat with alu_zero=0 -> pc unchanged.
- BNE: BnE=1, PCSrc=01, alu_out=32'h20, alu_zero=0 -> pc=32'h20. With alu_zero=1 -> pc held.
- Jump: pc=32'h1000_0004, instr=32'h0800_0010, PCWrite=1, PCSrc=10 -> pc=32'h1000_0040.
- Misalign and wrap: PCWrite=1, PCSrc=00, alu_result=32'h6 -> pc=6, pc_misalign=1, stays 1 after a later aligned write. With CNT_W=4, 16 IRWrite pulses -> instr_cnt wraps to 0.
